// File: rtl/bkm_steps_ctrl_pkg.sv
// Shared definitions for the BKM step sequencer: FSM state encodings,
// mode encodings and the default iteration geometry.
package bkm_steps_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } bkm_state_e;

  localparam logic MODE_E = 1'b0;  // exponential
  localparam logic MODE_L = 1'b1;  // logarithm

  localparam int N_ITER_DEF = 64;
  localparam int STEPS_DEF  = 4;

endpackage

// File: rtl/bkm_iter_counter.sv
// Loadable up-counter with a fixed stride and a registered terminal flag.
// term is a flop that always equals (cnt == TERM), so consumers see a clean
// registered compare rather than a decode of the count.
module bkm_iter_counter #(
  parameter int WIDTH  = 7,
  parameter int STRIDE = 1,
  parameter int TERM   = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             term
);

  localparam logic [WIDTH-1:0] TERM_V   = WIDTH'(TERM);
  localparam logic [WIDTH-1:0] STRIDE_V = WIDTH'(STRIDE);

  logic [WIDTH-1:0] cnt_d;

  // next count: clear beats load beats increment
  always_comb begin
    cnt_d = cnt;
    if (clr)      cnt_d = '0;
    else if (ld)  cnt_d = ld_val;
    else if (inc) cnt_d = cnt + STRIDE_V;
  end

  // count and terminal flag advance only on enabled cycles; srst wins
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt  <= '0;
      term <= (TERM_V == '0);
    end else if (srst) begin
      cnt  <= '0;
      term <= (TERM_V == '0);
    end else if (enable) begin
      cnt  <= cnt_d;
      term <= (cnt_d == TERM_V);
    end
  end

endmodule

// File: rtl/bkm_steps_ctrl.sv
// Sequencer for the bkm_steps datapath. Loads operands, issues N_ITER/STEPS
// step groups, waits PIPE cycles for the datapath to drain, then holds done
// until acknowledged. Carries no data, only mode and iteration index.
module bkm_steps_ctrl
  import bkm_steps_ctrl_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int STEPS  = STEPS_DEF,
  parameter int PIPE   = 1,
  parameter int WN     = $clog2(N_ITER + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          srst,
  input  logic          enable,
  input  logic          start,
  input  logic          mode,
  input  logic          done_ack,
  output logic          busy,
  output logic          load,
  output logic          step_en,
  output logic [WN-1:0] step_idx,
  output logic          last_grp,
  output logic          mode_q,
  output logic          done
);

  // index of the first iteration in the final group
  localparam int LAST_IDX = N_ITER - STEPS + 1;
  // flush counter needs at least one bit even when PIPE is 0
  localparam int WF = (PIPE < 1) ? 1 : $clog2(PIPE + 1);

  if (STEPS == 0 || (N_ITER % ((STEPS == 0) ? 1 : STEPS)) != 0) begin : g_bad_geom
    $error("bkm_steps_ctrl: N_ITER must be a nonzero multiple of STEPS");
  end

  bkm_state_e    state;
  logic          load_q;
  logic          step_en_q;
  logic          idx_clr, idx_ld, idx_inc, idx_term;
  logic          fl_ld, fl_inc, fl_term;
  logic [WF-1:0] fl_cnt;

  // counter controls decoded from the current state
  always_comb begin
    idx_clr = (state == ST_DONE) && done_ack;
    idx_ld  = (state == ST_LOAD);
    idx_inc = (state == ST_ITER) && !idx_term;
    fl_ld   = (state == ST_ITER) && idx_term;
    fl_inc  = (state == ST_FLUSH) && !fl_term;
  end

  // step_idx itself: loads 1, strides by STEPS, parks on the last group
  bkm_iter_counter #(
    .WIDTH (WN),
    .STRIDE(STEPS),
    .TERM  (LAST_IDX)
  ) u_idx_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .srst  (srst),
    .enable(enable),
    .clr   (idx_clr),
    .ld    (idx_ld),
    .ld_val(WN'(1)),
    .inc   (idx_inc),
    .cnt   (step_idx),
    .term  (idx_term)
  );

  // drain counter: loaded with 1 on entering FLUSH, terminal at PIPE
  bkm_iter_counter #(
    .WIDTH (WF),
    .STRIDE(1),
    .TERM  (PIPE)
  ) u_flush_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .srst  (srst),
    .enable(enable),
    .clr   (1'b0),
    .ld    (fl_ld),
    .ld_val(WF'(1)),
    .inc   (fl_inc),
    .cnt   (fl_cnt),
    .term  (fl_term)
  );

  // main FSM with registered outputs; everything freezes while enable is low
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      load_q    <= 1'b0;
      step_en_q <= 1'b0;
      mode_q    <= 1'b0;
      done      <= 1'b0;
    end else if (srst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      load_q    <= 1'b0;
      step_en_q <= 1'b0;
      mode_q    <= 1'b0;
      done      <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_LOAD;
          busy   <= 1'b1;
          load_q <= 1'b1;
          mode_q <= mode;
        end
        ST_LOAD: begin
          state     <= ST_ITER;
          load_q    <= 1'b0;
          step_en_q <= 1'b1;
        end
        ST_ITER: if (idx_term) begin
          step_en_q <= 1'b0;
          if (PIPE > 0) begin
            state <= ST_FLUSH;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_FLUSH: if (fl_term) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: if (done_ack) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          load_q    <= 1'b0;
          step_en_q <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // strobes are masked by enable so a frozen cycle never advances the datapath
  always_comb begin
    load     = load_q & enable;
    step_en  = step_en_q & enable;
    last_grp = step_en_q & idx_term;
  end

  // flush count value only matters through its terminal flag
  logic unused_fl;
  assign unused_fl = ^fl_cnt;

endmodule
